// File: rtl/adiv5_cmd_arbiter.sv
// adiv5_cmd_arbiter
//   Shares one ADIv5 command/response FIFO pair among NREQ requesters.
//   Commands are granted round-robin, one per cycle. A requester can hold
//   the grant across several commands with REQ_LOCK. Every command that
//   produces a response pushes its requester index into a tag FIFO, and
//   responses are routed back in command order using those tags.
//
// Ports
//   CLK        clock
//   RESET      synchronous reset, active-high
//   REQ_CMD    packed requester commands, requester i at [i*CMD_WIDTH +: CMD_WIDTH]
//   REQ_VALID  per-requester command valid
//   REQ_LOCK   keep the grant after this command is accepted
//   REQ_READY  per-requester command accept (combinational)
//   RSP_DATA   response payload, shared by all requesters
//   RSP_VALID  one-hot response valid, addressed to the issuing requester
//   RSP_READY  per-requester response consume
//   GRANT      one-hot lock owner, 0 when unlocked
//   WRDATA     command to the adiv5 command FIFO (combinational)
//   WREN       command FIFO push strobe (combinational)
//   WRFULL     command FIFO full
//   RDDATA     adiv5 response, valid the cycle after RDEN
//   RDEN       response FIFO pop strobe (combinational)
//   RDEMPTY    response FIFO empty
//   ERR        sticky: a response arrived with no outstanding tag
module adiv5_cmd_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned TAG_AW     = 2,
  parameter int unsigned CMD_WIDTH  = 36,
  parameter int unsigned RESP_WIDTH = 35
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NREQ*CMD_WIDTH-1:0] REQ_CMD,
  input  logic [NREQ-1:0]           REQ_VALID,
  input  logic [NREQ-1:0]           REQ_LOCK,
  output logic [NREQ-1:0]           REQ_READY,
  output logic [RESP_WIDTH-1:0]     RSP_DATA,
  output logic [NREQ-1:0]           RSP_VALID,
  input  logic [NREQ-1:0]           RSP_READY,
  output logic [NREQ-1:0]           GRANT,
  output logic [CMD_WIDTH-1:0]      WRDATA,
  output logic                      WREN,
  input  logic                      WRFULL,
  input  logic [RESP_WIDTH-1:0]     RDDATA,
  output logic                      RDEN,
  input  logic                      RDEMPTY,
  output logic                      ERR
);

  localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DEPTH = 32'd1 << TAG_AW;
  localparam int unsigned CW    = TAG_AW + 1;

  // DP[0xC] write (line reset / protocol switch) returns no response.
  localparam logic [3:0] SILENT_CODE = 4'b1100;

  localparam logic [1:0] RSP_IDLE  = 2'd0;
  localparam logic [1:0] RSP_FETCH = 2'd1;
  localparam logic [1:0] RSP_HOLD  = 2'd2;

  // ------------------------------------------------------------------
  // Arbitration state
  // ------------------------------------------------------------------
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        lock_idx;
  logic [IW-1:0]        cand;
  logic [IW-1:0]        scan_idx;
  logic                 scan_found;
  logic                 locked;
  logic                 can_issue;
  logic                 accept;
  logic                 expects_rsp;
  logic [CMD_WIDTH-1:0] cmd_sel;

  // ------------------------------------------------------------------
  // Tag FIFO state
  // ------------------------------------------------------------------
  logic [IW-1:0]     tag_mem [DEPTH];
  logic [TAG_AW-1:0] tag_wp;
  logic [TAG_AW-1:0] tag_rp;
  logic [CW-1:0]     tag_cnt;
  logic              tag_full;
  logic              tag_empty;
  logic              tag_push;
  logic              tag_pop;
  logic [IW-1:0]     tag_head;

  // ------------------------------------------------------------------
  // Response FSM state
  // ------------------------------------------------------------------
  logic [1:0]            rsp_state;
  logic [1:0]            rsp_state_n;
  logic [IW-1:0]         rsp_tag;
  logic [IW-1:0]         rsp_tag_n;
  logic [NREQ-1:0]       rsp_valid_n;
  logic [RESP_WIDTH-1:0] rsp_data_n;
  logic                  err_n;

  assign locked = |GRANT;

  // Candidate: lock owner when locked, else first valid after ptr.
  // With nothing valid the candidate defaults to ptr+1 so READY does
  // not depend on VALID beyond selection.
  always_comb begin
    cand       = IW'((32'(ptr) + 32'd1) % NREQ);
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((32'(ptr) + k) % NREQ);
      if (!scan_found && REQ_VALID[scan_idx]) begin
        cand       = scan_idx;
        scan_found = 1'b1;
      end
    end
    if (locked) begin
      cand = lock_idx;
    end
  end

  // A full tag FIFO blocks silent commands as well.
  assign can_issue   = !WRFULL && !tag_full && !RESET;
  assign REQ_READY   = can_issue ? (NREQ'(1) << cand) : '0;
  assign accept      = can_issue && REQ_VALID[cand];
  assign cmd_sel     = REQ_CMD[32'(cand)*CMD_WIDTH +: CMD_WIDTH];
  assign WRDATA      = cmd_sel;
  assign WREN        = accept;
  assign expects_rsp = (cmd_sel[3:0] != SILENT_CODE);
  assign tag_push    = accept && expects_rsp;

  // Round-robin pointer and lock ownership, updated on every accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr      <= '0;
      lock_idx <= '0;
      GRANT    <= '0;
    end else if (accept) begin
      ptr <= cand;
      if (REQ_LOCK[cand]) begin
        GRANT    <= NREQ'(1) << cand;
        lock_idx <= cand;
      end else begin
        GRANT <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Tag FIFO: requester index per outstanding response
  // ------------------------------------------------------------------
  assign tag_full  = (tag_cnt == CW'(DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[tag_rp];

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge CLK) begin
    if (tag_push) begin
      tag_mem[tag_wp] <= cand;
    end
  end

  // Pointers and count; simultaneous push and pop leave count unchanged.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_push) begin
        tag_wp <= tag_wp + TAG_AW'(1);
      end
      if (tag_pop) begin
        tag_rp <= tag_rp + TAG_AW'(1);
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Response FSM: IDLE pops the adiv5 FIFO, FETCH captures and tags,
  // HOLD waits for the addressed requester.
  // ------------------------------------------------------------------
  always_comb begin
    rsp_state_n = rsp_state;
    rsp_tag_n   = rsp_tag;
    rsp_valid_n = RSP_VALID;
    rsp_data_n  = RSP_DATA;
    err_n       = ERR;
    tag_pop     = 1'b0;
    RDEN        = 1'b0;
    case (rsp_state)
      RSP_IDLE: begin
        if (!RDEMPTY && !RESET) begin
          RDEN        = 1'b1;
          rsp_state_n = RSP_FETCH;
        end
      end
      RSP_FETCH: begin
        if (tag_empty) begin
          // Unsolicited response: flag it and drop the data.
          err_n       = 1'b1;
          rsp_state_n = RSP_IDLE;
        end else begin
          tag_pop     = 1'b1;
          rsp_data_n  = RDDATA;
          rsp_tag_n   = tag_head;
          rsp_valid_n = NREQ'(1) << tag_head;
          rsp_state_n = RSP_HOLD;
        end
      end
      RSP_HOLD: begin
        // Only the addressed requester can retire the response.
        if (RSP_READY[rsp_tag]) begin
          rsp_valid_n = '0;
          rsp_state_n = RSP_IDLE;
        end
      end
      default: begin
        rsp_state_n = RSP_IDLE;
      end
    endcase
  end

  // Response state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_state <= RSP_IDLE;
      rsp_tag   <= '0;
      RSP_VALID <= '0;
      RSP_DATA  <= '0;
      ERR       <= 1'b0;
    end else begin
      rsp_state <= rsp_state_n;
      rsp_tag   <= rsp_tag_n;
      RSP_VALID <= rsp_valid_n;
      RSP_DATA  <= rsp_data_n;
      ERR       <= err_n;
    end
  end

endmodule

// File: tb/tb_adiv5_cmd_arbiter.sv
// tb_adiv5_cmd_arbiter
//   Scenario bench for adiv5_cmd_arbiter with a behavioural adiv5 response
//   FIFO. Expected response owners are queued as tagged commands are issued
//   and expected payloads as responses are injected; both are popped when
//   the DUT presents a response.
module tb_adiv5_cmd_arbiter;

  localparam int unsigned NREQ       = 2;
  localparam int unsigned CMD_WIDTH  = 36;
  localparam int unsigned RESP_WIDTH = 35;

  logic                      CLK;
  logic                      RESET;
  logic [NREQ*CMD_WIDTH-1:0] REQ_CMD;
  logic [NREQ-1:0]           REQ_VALID;
  logic [NREQ-1:0]           REQ_LOCK;
  logic [NREQ-1:0]           REQ_READY;
  logic [RESP_WIDTH-1:0]     RSP_DATA;
  logic [NREQ-1:0]           RSP_VALID;
  logic [NREQ-1:0]           RSP_READY;
  logic [NREQ-1:0]           GRANT;
  logic [CMD_WIDTH-1:0]      WRDATA;
  logic                      WREN;
  logic                      WRFULL;
  logic [RESP_WIDTH-1:0]     RDDATA;
  logic                      RDEN;
  logic                      RDEMPTY;
  logic                      ERR;

  logic [CMD_WIDTH-1:0] cmd0;
  logic [CMD_WIDTH-1:0] cmd1;
  assign REQ_CMD = {cmd1, cmd0};

  int checks   = 0;
  int failures = 0;

  logic [RESP_WIDTH-1:0] mdl_q [$];
  logic [RESP_WIDTH-1:0] exp_data [$];
  int                    exp_owner [$];
  bit                    hold_rsp;

  adiv5_cmd_arbiter #(
    .NREQ(NREQ), .TAG_AW(2), .CMD_WIDTH(CMD_WIDTH), .RESP_WIDTH(RESP_WIDTH)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ_CMD(REQ_CMD), .REQ_VALID(REQ_VALID),
    .REQ_LOCK(REQ_LOCK), .REQ_READY(REQ_READY), .RSP_DATA(RSP_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .GRANT(GRANT),
    .WRDATA(WRDATA), .WREN(WREN), .WRFULL(WRFULL), .RDDATA(RDDATA),
    .RDEN(RDEN), .RDEMPTY(RDEMPTY), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [35:0] mkcmd(input logic [31:0] d, input logic [1:0] a,
                                        input logic apndp, input logic rnw);
    return {d, a, apndp, rnw};
  endfunction

  function automatic logic [34:0] mkrsp(input logic [31:0] d, input logic [2:0] s);
    return {d, s};
  endfunction

  // adiv5 response FIFO model: RDDATA is updated just after the edge that
  // follows an RDEN cycle.
  initial begin
    RDEMPTY = 1'b1;
    RDDATA  = '0;
    forever begin
      @(negedge CLK);
      #2;
      RDEMPTY = hold_rsp || (mdl_q.size() == 0);
      #1;
      if (RDEN === 1'b1) begin
        @(posedge CLK);
        #1;
        if (mdl_q.size() > 0) RDDATA = mdl_q.pop_front();
        RDEMPTY = hold_rsp || (mdl_q.size() == 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge CLK);
    REQ_VALID = 2'b11;
    cmd0 = mkcmd(32'h1, 2'b11, 1'b0, 1'b0);
    cmd1 = mkcmd(32'h2, 2'b11, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b00 || WREN !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got ready=%b wren=%b exp ready=00 wren=0", REQ_READY, WREN);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (RSP_VALID !== 2'b00 || GRANT !== 2'b00 || ERR !== 1'b0 || RDEN !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got rsp_valid=%b grant=%b err=%b rden=%b exp 00 00 0 0",
               RSP_VALID, GRANT, ERR, RDEN);
    end
    @(negedge CLK);
    RESET = 1'b0;
    REQ_VALID = 2'b00;
    #1;
    // Pointer at 0 selects requester 1 first.
    checks++;
    if (REQ_READY !== 2'b10) begin
      failures++;
      $display("FAIL reset_ptr got ready=%b exp 10", REQ_READY);
    end
  endtask

  task automatic test_round_robin();
    int e;
    int acc;
    @(negedge CLK);
    WRFULL = 1'b1;
    REQ_VALID = 2'b10;
    cmd1 = mkcmd(32'hA5A50001, 2'b11, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b00 || WREN !== 1'b0) begin
      failures++;
      $display("FAIL wrfull_block got ready=%b wren=%b exp 00 0", REQ_READY, WREN);
    end
    @(negedge CLK);
    WRFULL = 1'b0;
    #1;
    checks++;
    if (REQ_READY !== 2'b10 || WREN !== 1'b1 || WRDATA !== cmd1) begin
      failures++;
      $display("FAIL rr_prime got ready=%b wren=%b wrdata=%h exp 10 1 %h",
               REQ_READY, WREN, WRDATA, cmd1);
    end
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      REQ_VALID = 2'b11;
      cmd0 = mkcmd(32'h100 + 32'(k), 2'b11, 1'b0, 1'b0);
      cmd1 = mkcmd(32'h200 + 32'(k), 2'b11, 1'b0, 1'b0);
      #1;
      e = k % 2;
      checks++;
      if (REQ_READY !== 2'(1 << e) || WRDATA !== ((e == 0) ? cmd0 : cmd1)) begin
        failures++;
        $display("FAIL rr_grant k=%0d got ready=%b wrdata=%h exp ready=%b wrdata=%h",
                 k, REQ_READY, WRDATA, 2'(1 << e), (e == 0) ? cmd0 : cmd1);
      end
      if (WREN === 1'b1) acc++;
    end
    checks++;
    if (acc != 4) begin
      failures++;
      $display("FAIL rr_accepts got %0d exp 4", acc);
    end
    @(negedge CLK);
    REQ_VALID = 2'b00;
  endtask

  task automatic test_lock();
    int eo;
    logic [34:0] ed;
    logic [34:0] r;
    bit seen;
    @(negedge CLK);
    REQ_VALID = 2'b01;
    cmd0 = mkcmd(32'h300, 2'b11, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL lock_setup got ready=%b exp 01", REQ_READY);
    end
    @(negedge CLK);
    REQ_VALID = 2'b11;
    REQ_LOCK = 2'b10;
    cmd1 = mkcmd(32'h000000F0, 2'b10, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b10 || WRDATA !== cmd1) begin
      failures++;
      $display("FAIL lock_take got ready=%b wrdata=%h exp 10 %h", REQ_READY, WRDATA, cmd1);
    end
    exp_owner.push_back(1);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      REQ_VALID = 2'b01;
      REQ_LOCK = 2'b00;
      #1;
      checks++;
      if (REQ_READY !== 2'b10 || WREN !== 1'b0 || GRANT !== 2'b10) begin
        failures++;
        $display("FAIL lock_stall c=%0d got ready=%b wren=%b grant=%b exp 10 0 10",
                 c, REQ_READY, WREN, GRANT);
      end
    end
    @(negedge CLK);
    REQ_VALID = 2'b11;
    cmd1 = mkcmd(32'h0, 2'b00, 1'b1, 1'b1);
    #1;
    checks++;
    if (REQ_READY !== 2'b10 || WRDATA !== cmd1) begin
      failures++;
      $display("FAIL lock_release got ready=%b wrdata=%h exp 10 %h", REQ_READY, WRDATA, cmd1);
    end
    exp_owner.push_back(1);
    @(negedge CLK);
    REQ_VALID = 2'b01;
    #1;
    checks++;
    if (GRANT !== 2'b00 || REQ_READY !== 2'b01 || WREN !== 1'b1 || WRDATA !== cmd0) begin
      failures++;
      $display("FAIL lock_after got grant=%b ready=%b wren=%b wrdata=%h exp 00 01 1 %h",
               GRANT, REQ_READY, WREN, WRDATA, cmd0);
    end
    @(negedge CLK);
    REQ_VALID = 2'b00;
    for (int n = 0; n < 2; n++) begin
      r = mkrsp(32'h5A000000 + 32'(n), 3'b100);
      mdl_q.push_back(r);
      exp_data.push_back(r);
    end
    for (int n = 0; n < 2; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge CLK);
        #1;
        if (RSP_VALID !== 2'b00) begin
          seen = 1'b1;
          eo = exp_owner.pop_front();
          ed = exp_data.pop_front();
          checks++;
          if (RSP_VALID !== 2'(1 << eo) || RSP_DATA !== ed) begin
            failures++;
            $display("FAIL lock_rsp n=%0d got valid=%b data=%h exp %b %h",
                     n, RSP_VALID, RSP_DATA, 2'(1 << eo), ed);
          end
        end
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL lock_rsp_timeout n=%0d got no response exp one", n);
      end
    end
  endtask

  task automatic test_tagging();
    int eo;
    logic [34:0] ed;
    bit seen;
    @(negedge CLK);
    REQ_VALID = 2'b01;
    cmd0 = mkcmd(32'h0, 2'b11, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b01 || WREN !== 1'b1) begin
      failures++;
      $display("FAIL tag_silent got ready=%b wren=%b exp 01 1", REQ_READY, WREN);
    end
    @(negedge CLK);
    cmd0 = mkcmd(32'h0, 2'b00, 1'b0, 1'b1);
    #1;
    checks++;
    if (REQ_READY !== 2'b01 || WREN !== 1'b1 || WRDATA !== cmd0) begin
      failures++;
      $display("FAIL tag_dpread got ready=%b wren=%b wrdata=%h exp 01 1 %h",
               REQ_READY, WREN, WRDATA, cmd0);
    end
    exp_owner.push_back(0);
    @(negedge CLK);
    REQ_VALID = 2'b00;
    mdl_q.push_back(mkrsp(32'h12345678, 3'b100));
    exp_data.push_back({32'h12345678, 3'b100});
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge CLK);
      #1;
      if (RSP_VALID !== 2'b00) begin
        seen = 1'b1;
        eo = exp_owner.pop_front();
        ed = exp_data.pop_front();
        checks++;
        if (RSP_VALID !== 2'(1 << eo) || RSP_DATA !== ed) begin
          failures++;
          $display("FAIL tag_rsp got valid=%b data=%h exp %b %h",
                   RSP_VALID, RSP_DATA, 2'(1 << eo), ed);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL tag_rsp_timeout got no response exp one");
    end
    repeat (4) @(negedge CLK);
    #1;
    // The silent command must not have left a stray tag behind.
    checks++;
    if (ERR !== 1'b0 || RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL tag_clean got err=%b valid=%b exp 0 00", ERR, RSP_VALID);
    end
  endtask

  task automatic test_tag_full();
    int eo;
    logic [34:0] ed;
    logic [34:0] r;
    bit seen;
    hold_rsp = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      REQ_VALID = 2'b10;
      cmd1 = mkcmd(32'h4000 + 32'(k), 2'b01, 1'b0, 1'b1);
      #1;
      checks++;
      if (REQ_READY !== 2'b10 || WREN !== 1'b1) begin
        failures++;
        $display("FAIL full_fill k=%0d got ready=%b wren=%b exp 10 1", k, REQ_READY, WREN);
      end
      exp_owner.push_back(1);
    end
    @(negedge CLK);
    REQ_VALID = 2'b11;
    cmd0 = mkcmd(32'h0, 2'b11, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b00 || WREN !== 1'b0) begin
      failures++;
      $display("FAIL full_block got ready=%b wren=%b exp 00 0", REQ_READY, WREN);
    end
    @(negedge CLK);
    REQ_VALID = 2'b00;
    for (int k = 0; k < 4; k++) begin
      r = mkrsp(32'h77000000 + 32'(k), 3'b100);
      mdl_q.push_back(r);
      exp_data.push_back(r);
    end
    hold_rsp = 1'b0;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge CLK);
        #1;
        if (RSP_VALID !== 2'b00) begin
          seen = 1'b1;
          if (n == 0) begin
            checks++;
            if (REQ_READY !== 2'b01) begin
              failures++;
              $display("FAIL full_reassert got ready=%b exp 01", REQ_READY);
            end
          end
          eo = exp_owner.pop_front();
          ed = exp_data.pop_front();
          checks++;
          if (RSP_VALID !== 2'(1 << eo) || RSP_DATA !== ed) begin
            failures++;
            $display("FAIL full_rsp n=%0d got valid=%b data=%h exp %b %h",
                     n, RSP_VALID, RSP_DATA, 2'(1 << eo), ed);
          end
        end else if (n == 0) begin
          checks++;
          if (REQ_READY !== 2'b00) begin
            failures++;
            $display("FAIL full_hold c=%0d got ready=%b exp 00", c, REQ_READY);
          end
        end
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL full_rsp_timeout n=%0d got no response exp one", n);
      end
    end
  endtask

  task automatic test_backpressure();
    int eo;
    logic [34:0] ed;
    logic [34:0] d0;
    logic [34:0] d1;
    bit seen;
    d0 = mkrsp(32'hCAFE0000, 3'b001);
    d1 = mkrsp(32'hBEEF1111, 3'b010);
    @(negedge CLK);
    REQ_VALID = 2'b01;
    cmd0 = mkcmd(32'h0, 2'b01, 1'b0, 1'b1);
    #1;
    checks++;
    if (REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL bp_cmd0 got ready=%b exp 01", REQ_READY);
    end
    exp_owner.push_back(0);
    @(negedge CLK);
    REQ_VALID = 2'b10;
    cmd1 = mkcmd(32'h0, 2'b11, 1'b1, 1'b1);
    #1;
    checks++;
    if (REQ_READY !== 2'b10) begin
      failures++;
      $display("FAIL bp_cmd1 got ready=%b exp 10", REQ_READY);
    end
    exp_owner.push_back(1);
    @(negedge CLK);
    REQ_VALID = 2'b00;
    RSP_READY = 2'b00;
    mdl_q.push_back(d0);
    exp_data.push_back(d0);
    mdl_q.push_back(d1);
    exp_data.push_back(d1);
    eo = 0;
    ed = '0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge CLK);
      #1;
      if (RSP_VALID !== 2'b00) begin
        seen = 1'b1;
        eo = exp_owner.pop_front();
        ed = exp_data.pop_front();
        checks++;
        if (RSP_VALID !== 2'(1 << eo) || RSP_DATA !== ed) begin
          failures++;
          $display("FAIL bp_first got valid=%b data=%h exp %b %h",
                   RSP_VALID, RSP_DATA, 2'(1 << eo), ed);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bp_first_timeout got no response exp one");
    end
    // Second half of the hold raises the non-target ready, which must be ignored.
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      RSP_READY = (c < 5) ? 2'b00 : 2'b10;
      #1;
      checks++;
      if (RSP_VALID !== 2'(1 << eo) || RSP_DATA !== ed || RDEN !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d got valid=%b data=%h rden=%b exp %b %h 0",
                 c, RSP_VALID, RSP_DATA, RDEN, 2'(1 << eo), ed);
      end
    end
    @(negedge CLK);
    RSP_READY = 2'b01;
    @(negedge CLK);
    #1;
    checks++;
    if (RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL bp_consume got valid=%b exp 00", RSP_VALID);
    end
    RSP_READY = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge CLK);
      #1;
      if (RSP_VALID !== 2'b00) begin
        seen = 1'b1;
        eo = exp_owner.pop_front();
        ed = exp_data.pop_front();
        checks++;
        if (RSP_VALID !== 2'(1 << eo) || RSP_DATA !== ed) begin
          failures++;
          $display("FAIL bp_second got valid=%b data=%h exp %b %h",
                   RSP_VALID, RSP_DATA, 2'(1 << eo), ed);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL bp_second_timeout got no response exp one");
    end
  endtask

  task automatic test_err();
    @(negedge CLK);
    RSP_READY = 2'b11;
    mdl_q.push_back(mkrsp(32'h0BAD0BAD, 3'b100));
    @(negedge CLK);
    #1;
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_early got err=%b exp 0", ERR);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (ERR !== 1'b1 || RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL err_set got err=%b valid=%b exp 1 00", ERR, RSP_VALID);
    end
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (ERR !== 1'b1 || RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL err_sticky got err=%b valid=%b exp 1 00", ERR, RSP_VALID);
    end
    @(negedge CLK);
    REQ_VALID = 2'b01;
    REQ_LOCK = 2'b01;
    cmd0 = mkcmd(32'h0, 2'b11, 1'b0, 1'b0);
    #1;
    checks++;
    if (REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL err_lock_take got ready=%b exp 01", REQ_READY);
    end
    @(negedge CLK);
    REQ_VALID = 2'b00;
    REQ_LOCK = 2'b00;
    #1;
    checks++;
    if (GRANT !== 2'b01 || REQ_READY !== 2'b01) begin
      failures++;
      $display("FAIL err_locked got grant=%b ready=%b exp 01 01", GRANT, REQ_READY);
    end
    @(negedge CLK);
    RESET = 1'b1;
    mdl_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++;
    if (ERR !== 1'b0 || GRANT !== 2'b00 || REQ_READY !== 2'b10 || RSP_VALID !== 2'b00) begin
      failures++;
      $display("FAIL err_reset got err=%b grant=%b ready=%b valid=%b exp 0 00 10 00",
               ERR, GRANT, REQ_READY, RSP_VALID);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    REQ_VALID = '0;
    REQ_LOCK  = '0;
    RSP_READY = 2'b11;
    WRFULL    = 1'b0;
    hold_rsp  = 1'b0;
    cmd0      = '0;
    cmd1      = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_tagging();
    test_tag_full();
    test_backpressure();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
